// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-side divider request/stall FSM owning HI/LO; DIV_ZERO_BYPASS_EN skips issue on divide-by-zero
module div_issue_ctrl #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_div_op,
    input  logic            ex_div_sign,
    input  logic [DW-1:0]   ex_rs_val,
    input  logic [DW-1:0]   ex_rt_val,
    input  logic            ex_flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [DW-1:0]   hilo_wdata,
    output logic            div_valid,
    output logic            div_sign,
    output logic [DW-1:0]   div_a,
    output logic [DW-1:0]   div_b,
    input  logic            div_run,
    input  logic [2*DW-1:0] div_result,
    output logic            div_ready,
    output logic            stall_div,
    output logic [DW-1:0]   hi_out,
    output logic [DW-1:0]   lo_out
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
    state_t state_q, state_d;
    logic sign_q, sign_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic take, zero_div, res_we;
`ifdef DIV_ZERO_BYPASS_EN
    assign zero_div = ex_rt_val == '0;
`else
    assign zero_div = 1'b0;
`endif
    assign take      = ex_div_op & ~ex_flush;
    assign div_valid = state_q == ISSUE;
    assign div_ready = (state_q == WAIT || state_q == DRAIN) && div_run;
    assign stall_div = take && state_q != DONE;
    assign res_we    = state_q == WAIT && div_run && !ex_flush;
    assign div_sign  = sign_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = take ? (zero_div ? DONE : ISSUE) : IDLE;
            ISSUE:   state_d = ex_flush ? DRAIN : WAIT;
            WAIT:    state_d = div_run ? (ex_flush ? IDLE : DONE) : (ex_flush ? DRAIN : WAIT);
            DRAIN:   state_d = div_run ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        sign_d = sign_q;
        a_d    = a_q;
        b_d    = b_q;
        if (state_q == IDLE && take && !zero_div) begin
            sign_d = ex_div_sign;
            a_d    = ex_rs_val;
            b_d    = ex_rt_val;
        end
        // a divider write on this edge overrides any MTHI/MTLO
        hi_d = res_we ? div_result[2*DW-1:DW] : (hi_we ? hilo_wdata : hi_q);
        lo_d = res_we ? div_result[DW-1:0]    : (lo_we ? hilo_wdata : lo_q);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: scoreboard bench with a behavioural divider stub and arithmetic HI/LO reference
module tb_div_issue_ctrl;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ex_div_op = 1'b0, ex_div_sign = 1'b0, ex_flush = 1'b0;
    logic [DW-1:0] ex_rs_val = '0, ex_rt_val = '0, hilo_wdata = '0;
    logic hi_we = 1'b0, lo_we = 1'b0;
    logic div_valid, div_sign, div_ready, stall_div;
    logic [DW-1:0] div_a, div_b, hi_out, lo_out;
    logic div_run = 1'b0;
    logic [2*DW-1:0] div_result = '0;

    int total = 0, bad = 0;
    int cyc = 0, lat = 0, nvalid = 0, valid_cyc = 0, done_cyc = 0;
    bit dbusy = 1'b0;
    logic [DW-1:0] mh = '0, ml = '0;
    logic [2*DW:0] exp_iss[$];
    logic [2*DW-1:0] exp_hl[$];

    div_issue_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .ex_div_op(ex_div_op), .ex_div_sign(ex_div_sign),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_flush(ex_flush),
        .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
        .div_valid(div_valid), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
        .div_run(div_run), .div_result(div_result), .div_ready(div_ready),
        .stall_div(stall_div), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // MIPS quotient/remainder via 64-bit arithmetic; divide-by-zero returns {a, all-ones}
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // divider stub: samples at negedge, updates just after posedge
    initial begin
        logic v, r;
        logic [63:0] res;
        int cnt;
        res = '0;
        cnt = 0;
        forever begin
            @(negedge clk);
            v = div_valid;
            r = div_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                div_run = 1'b0;
                dbusy = 1'b0;
            end else if (div_run && r) begin
                div_run = 1'b0;
                dbusy = 1'b0;
                div_result = '0;
            end else if (v) begin
                dbusy = 1'b1;
                cnt = lat;
                res = ref_div(div_a, div_b, div_sign);
            end else if (dbusy && !div_run) begin
                if (cnt == 0) begin
                    div_run = 1'b1;
                    div_result = res;
                end else cnt--;
            end
        end
    end

    // monitor: pops issue expectations on div_valid and HI/LO expectations on div_ready
    initial begin
        logic [63:0] pend;
        logic [64:0] e;
        bit chk;
        chk = 1'b0;
        pend = '0;
        forever begin
            @(negedge clk);
            if (chk) begin
                check("hilo_after_ready", {hi_out, lo_out}, pend);
                chk = 1'b0;
            end
            if (rst && div_valid) begin
                nvalid++;
                valid_cyc = cyc;
                if (exp_iss.size() == 0) check("unexpected_div_valid", 64'd1, 64'd0);
                else begin
                    e = exp_iss.pop_front();
                    check("issue_sign", {63'd0, div_sign}, {63'd0, e[64]});
                    check("issue_operands", {div_a, div_b}, e[63:0]);
                end
            end
            if (rst && div_ready) begin
                if (exp_hl.size() == 0) check("unexpected_div_ready", 64'd1, 64'd0);
                else begin
                    pend = exp_hl.pop_front();
                    chk = 1'b1;
                end
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        check({tag, "_valid_ready_sign_stall"}, {60'd0, div_valid, div_ready, div_sign, stall_div}, 64'd0);
        check({tag, "_div_ab"}, {div_a, div_b}, 64'd0);
        check({tag, "_hilo"}, {hi_out, lo_out}, 64'd0);
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] d);
        hi_we = to_hi;
        lo_we = !to_hi;
        hilo_wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (to_hi) mh = d; else ml = d;
        check(to_hi ? "mthi" : "mtlo", {hi_out, lo_out}, {mh, ml});
    endtask

    // f < 0: no flush; f >= 0: flush f cycles after the ISSUE cycle
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int f, input int l);
        logic [63:0] r;
        int n, v0;
        bit byp;
        byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        byp = (b == 0);
`endif
        lat = l;
        v0 = nvalid;
        r = ref_div(a, b, s);
        if (!byp) begin
            exp_iss.push_back({s, a, b});
            if (f < 0) begin
                mh = r[63:32];
                ml = r[31:0];
            end
            exp_hl.push_back({mh, ml});
        end
        ex_div_op = 1'b1;
        ex_rs_val = a;
        ex_rt_val = b;
        ex_div_sign = s;
        #1;
        check("stall_on_detect", {63'd0, stall_div}, 64'd1);
        n = 0;
        if (f >= 0) begin
            while (n < f + 1) begin
                @(negedge clk);
                n++;
            end
            ex_flush = 1'b1;
            #1;
            check("stall_drop_on_flush", {63'd0, stall_div}, 64'd0);
            @(negedge clk);
            ex_flush = 1'b0;
            ex_div_op = 1'b0;
            n = 0;
            while ((dbusy || div_run) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("drain_timeout", {63'd0, n >= 200}, 64'd0);
            check("flush_issue_count", 64'(nvalid - v0), 64'd1);
        end else begin
            do begin
                @(negedge clk);
                n++;
            end while (stall_div && n < 200);
            check("stall_cycles", 64'(n), byp ? 64'd1 : 64'(l + 4));
            done_cyc = cyc;
            @(negedge clk);
            ex_div_op = 1'b0;
            check("issue_count", 64'(nvalid - v0), byp ? 64'd0 : 64'd1);
            if (byp) check("bypass_hilo_kept", {hi_out, lo_out}, {mh, ml});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int prev_done, f, l;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b1;
        @(negedge clk);

        do_div(32'd100, 32'd7, 1'b0, -1, 34);
        check("divu_100_7", {hi_out, lo_out}, {32'd2, 32'd14});
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, 5);
        check("div_m7_2", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        mt(1'b1, 32'h1111_1111);
        mt(1'b0, 32'h2222_2222);
        do_div(32'd1000, 32'd3, 1'b0, 10, 20);
        @(negedge clk);
        check("flush_hilo_kept", {hi_out, lo_out}, {32'h1111_1111, 32'h2222_2222});

        do_div(32'd9, 32'd3, 1'b0, -1, 3);
        check("b2b_first", {hi_out, lo_out}, {32'd0, 32'd3});
        prev_done = done_cyc;
        do_div(32'd10, 32'd4, 1'b0, -1, 3);
        check("b2b_second", {hi_out, lo_out}, {32'd2, 32'd2});
        check("b2b_issue_gap", 64'(valid_cyc - prev_done), 64'd2);

        do_div(32'd77, 32'd5, 1'b0, 3, 1);
        mt(1'b1, 32'h0000_ABCD);
        check("mthi_abcd", {32'd0, hi_out}, {32'd0, 32'h0000_ABCD});

        lat = 30;
        exp_iss.push_back({1'b1, 32'd50, 32'd5});
        exp_hl.push_back({32'd0, 32'd10});
        ex_div_op = 1'b1;
        ex_div_sign = 1'b1;
        ex_rs_val = 32'd50;
        ex_rt_val = 32'd5;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        ex_div_op = 1'b0;
        @(negedge clk);
        chk_reset_outs("reset_in_wait");
        rst = 1'b1;
        exp_hl.delete();
        mh = '0;
        ml = '0;
        @(negedge clk);

        mt(1'b1, 32'h0000_0123);
        do_div(32'd5, 32'd0, 1'b1, -1, 4);

        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom % 2) ? $urandom_range(1, 50) : $urandom);
            if (b == 0) b = ($urandom % 3 == 0) ? 32'd0 : 32'd1;
            f = (b != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
            l = (f >= 2) ? f - 2 + $urandom_range(0, 3) : $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) mt($urandom % 2, $urandom);
            do_div(a, b, $urandom % 2, f, l);
        end

        repeat (3) @(negedge clk);
        check("issue_queue_empty", 64'(exp_iss.size()), 64'd0);
        check("hilo_queue_empty", 64'(exp_hl.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
